vend_ctrl_param: RTL and testbench

- Parametrised vending controller; successor to the fixed 2-coin/1-product FSM.
- Accumulates credit from two coin inputs of configurable value and serves two products with independent prices.
- Returns change serially, one unit per cycle, and supports cancel/refund.
- Sits behind the tile's ui_in/uo_out mapping in the top-level wrapper.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_change_ctr.sv | 37 +++
 rtl/vend_ctrl_param.sv | 197 +++++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and defaults for the parametrised vending controller.
package vend_pkg;

    // Controller states: IDLE holds no credit, CREDIT accumulates coins,
    // VEND is the one-cycle dispense step, CHANGE pays out one unit per cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int DEF_COIN_A_VAL = 1;
    localparam int DEF_COIN_B_VAL = 2;
    localparam int DEF_PRICE0     = 3;
    localparam int DEF_PRICE1     = 5;

    // Price lookup for a product index given the two configured prices.
    function automatic int price_of(input logic id, input int price0, input int price1);
        return id ? price1 : price0;
    endfunction

endpackage

// File: rtl/vend_change_ctr.sv
// Loadable down-counter that pays out change one unit per enabled cycle.
// The change pulse is registered; done is high whenever the count is zero.
module vend_change_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         change,
    output logic         done
);

    assign done = (count == '0);

    // Load takes priority over decrement; each decrement emits one change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            change <= 1'b0;
        end else if (ena) begin
            if (load) begin
                count  <= load_val;
                change <= 1'b0;
            end else if (dec && !done) begin
                count  <= count - W'(1);
                change <= 1'b1;
            end else begin
                change <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised two-coin / two-product vending controller with serial change.
// Optional idle auto-refund is compiled in when VEND_TIMEOUT_EN is defined.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 4,
    parameter int COIN_A_VAL  = DEF_COIN_A_VAL,
    parameter int COIN_B_VAL  = DEF_COIN_B_VAL,
    parameter int PRICE0      = DEF_PRICE0,
    parameter int PRICE1      = DEF_PRICE1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                sel_valid,
    input  logic                sel_id,
    input  logic                cancel,
    output logic                vend,
    output logic                vend_id,
    output logic                change,
    output logic                coin_reject,
    output logic                deny,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    localparam int EW = CREDIT_W + 1;
    localparam logic [CREDIT_W:0] MAX_CREDIT = EW'((1 << CREDIT_W) - 1);
    localparam logic [CREDIT_W:0] VAL_A      = EW'(COIN_A_VAL);
    localparam logic [CREDIT_W:0] VAL_B      = EW'(COIN_B_VAL);

    state_t              state;
    state_t              next_state;
    logic                coin_any;
    logic                dual_coin;
    logic                in_entry;
    logic                cancel_hit;
    logic                sel_hit;
    logic                sel_ok;
    logic                coin_slot;
    logic                coin_ok;
    logic                timeout_hit;
    logic [CREDIT_W:0]   credit_ext;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W:0]   sel_price;
    logic [CREDIT_W-1:0] vend_price;
    logic [CREDIT_W-1:0] remainder;
    logic [CREDIT_W-1:0] credit_nxt;
    logic [CREDIT_W-1:0] ctr_load_val;
    logic [CREDIT_W-1:0] ctr_count;
    logic                vend_d;
    logic                vend_id_d;
    logic                coin_reject_d;
    logic                deny_d;
    logic                busy_d;
    logic                ctr_load;
    logic                ctr_dec;
    logic                ctr_done;

    // Input decode: cancel beats select, select beats coins; coin_b beats coin_a.
    assign credit_ext = {1'b0, credit};
    assign coin_any   = coin_a | coin_b;
    assign dual_coin  = coin_a & coin_b;
    assign coin_val   = coin_b ? VAL_B : VAL_A;
    assign coin_sum   = credit_ext + coin_val;
    assign sel_price  = EW'(price_of(sel_id, PRICE0, PRICE1));
    assign vend_price = CREDIT_W'(price_of(vend_id, PRICE0, PRICE1));
    assign remainder  = credit - vend_price;
    assign in_entry   = (state == IDLE) || (state == CREDIT);
    assign cancel_hit = (state == CREDIT) && cancel;
    assign sel_hit    = (state == CREDIT) && !cancel && sel_valid;
    assign sel_ok     = sel_hit && (credit_ext >= sel_price);
    assign coin_slot  = in_entry && !cancel && !sel_valid && coin_any;
    assign coin_ok    = coin_slot && (coin_sum <= MAX_CREDIT);

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          quiet;

    assign quiet       = (state == CREDIT) && !coin_any && !sel_valid && !cancel;
    assign timeout_hit = quiet && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Count consecutive quiet cycles in CREDIT; any activity or leaving CREDIT clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (ena) begin
            if (quiet && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    // No auto-refund: credit is held until the customer acts.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYC > 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (coin_ok) next_state = CREDIT;
            end
            CREDIT: begin
                if (cancel_hit || timeout_hit) next_state = CHANGE;
                else if (sel_ok)               next_state = VEND;
            end
            VEND: begin
                next_state = (remainder != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (ctr_done || ctr_count == CREDIT_W'(1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, credit and change-counter controls.
    always_comb begin
        vend_d        = sel_ok;
        vend_id_d     = sel_ok ? sel_id : vend_id;
        deny_d        = sel_hit && !sel_ok;
        coin_reject_d = coin_any && !(coin_ok && !dual_coin);
        busy_d        = (next_state == VEND) || (next_state == CHANGE);
        credit_nxt    = credit;
        ctr_load      = 1'b0;
        ctr_load_val  = credit;
        ctr_dec       = 1'b0;
        case (state)
            IDLE, CREDIT: begin
                if (cancel_hit || timeout_hit) ctr_load   = 1'b1;
                else if (coin_ok)              credit_nxt = coin_sum[CREDIT_W-1:0];
            end
            VEND: begin
                credit_nxt   = remainder;
                ctr_load     = (remainder != '0);
                ctr_load_val = remainder;
            end
            CHANGE: begin
                ctr_dec = 1'b1;
                if (credit != '0) credit_nxt = credit - CREDIT_W'(1);
            end
            default: ;
        endcase
    end

    // Registered outputs and credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vend        <= 1'b0;
            vend_id     <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
            busy        <= 1'b0;
            credit      <= '0;
        end else if (ena) begin
            vend        <= vend_d;
            vend_id     <= vend_id_d;
            coin_reject <= coin_reject_d;
            deny        <= deny_d;
            busy        <= busy_d;
            credit      <= credit_nxt;
        end
    end

    vend_change_ctr #(
        .W (CREDIT_W)
    ) u_change_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .count    (ctr_count),
        .change   (change),
        .done     (ctr_done)
    );

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed self-checking bench for vend_ctrl_param (default prices 3/5, coins 1/2).
// With VEND_TIMEOUT_EN defined the auto-refund after 8 quiet cycles is exercised.
module tb_vend_ctrl_param;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       coin_a;
    logic       coin_b;
    logic       sel_valid;
    logic       sel_id;
    logic       cancel;
    logic       vend;
    logic       vend_id;
    logic       change;
    logic       coin_reject;
    logic       deny;
    logic       busy;
    logic [3:0] credit;

    logic [9:0] obs;
    logic [9:0] want;
    int         checks;
    int         errors;

    assign obs = {vend, vend_id, change, coin_reject, deny, busy, credit};

    vend_ctrl_param #(
        .CREDIT_W    (4),
        .COIN_A_VAL  (1),
        .COIN_B_VAL  (2),
        .PRICE0      (3),
        .PRICE1      (5),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .coin_a      (coin_a),
        .coin_b      (coin_b),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .cancel      (cancel),
        .vend        (vend),
        .vend_id     (vend_id),
        .change      (change),
        .coin_reject (coin_reject),
        .deny        (deny),
        .busy        (busy),
        .credit      (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector {vend, vend_id, change, coin_reject, deny, busy, credit}.
    function automatic logic [9:0] pack(input logic v, input logic id, input logic ch,
                                        input logic rej, input logic dn, input logic bs,
                                        input logic [3:0] cr);
        return {v, id, ch, rej, dn, bs, cr};
    endfunction

    // Drive one cycle of inputs, let the edge pass, then return inputs to quiet.
    task automatic applyStimulus(input logic a, input logic b, input logic sv,
                                 input logic sid, input logic cn);
        coin_a = a; coin_b = b; sel_valid = sv; sel_id = sid; cancel = cn;
        @(posedge clk);
        #1;
        coin_a = 1'b0; coin_b = 1'b0; sel_valid = 1'b0; sel_id = 1'b0; cancel = 1'b0;
    endtask

    task automatic do_reset();
        ena = 1'b1;
        coin_a = 1'b0; coin_b = 1'b0; sel_valid = 1'b0; sel_id = 1'b0; cancel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ena = 1'b1;
        coin_a = 1'b0; coin_b = 1'b0; sel_valid = 1'b0; sel_id = 1'b0; cancel = 1'b0;
        rst_n = 1'b0;
        #3;
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL reset_async: got %b want %b", obs, want); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL reset_idle: got %b want %b", obs, want); end
    endtask

    task automatic test_vend_with_change();
        do_reset();
        applyStimulus(1,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd1); if (obs !== want) begin errors++; $display("[TB] FAIL vc_coin_a: got %b want %b", obs, want); end
        applyStimulus(0,1,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd3); if (obs !== want) begin errors++; $display("[TB] FAIL vc_coin_b: got %b want %b", obs, want); end
        applyStimulus(1,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd4); if (obs !== want) begin errors++; $display("[TB] FAIL vc_credit4: got %b want %b", obs, want); end
        applyStimulus(0,0,1,0,0);
        checks++; want = pack(1,0,0,0,0,1,4'd4); if (obs !== want) begin errors++; $display("[TB] FAIL vc_vend: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,1,4'd1); if (obs !== want) begin errors++; $display("[TB] FAIL vc_after_vend: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL vc_change1: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL vc_idle: got %b want %b", obs, want); end
    endtask

    task automatic test_deny_cancel();
        do_reset();
        applyStimulus(0,1,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL dc_coin_b: got %b want %b", obs, want); end
        applyStimulus(0,0,1,1,0);
        checks++; want = pack(0,0,0,0,1,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL dc_deny: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL dc_deny_drop: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,1);
        checks++; want = pack(0,0,0,0,0,1,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL dc_cancel: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,1,4'd1); if (obs !== want) begin errors++; $display("[TB] FAIL dc_change1: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL dc_change2: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL dc_idle: got %b want %b", obs, want); end
    endtask

    task automatic test_overflow();
        do_reset();
        repeat (7) applyStimulus(0,1,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd14); if (obs !== want) begin errors++; $display("[TB] FAIL ov_credit14: got %b want %b", obs, want); end
        applyStimulus(0,1,0,0,0);
        checks++; want = pack(0,0,0,1,0,0,4'd14); if (obs !== want) begin errors++; $display("[TB] FAIL ov_reject: got %b want %b", obs, want); end
        applyStimulus(1,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd15); if (obs !== want) begin errors++; $display("[TB] FAIL ov_credit15: got %b want %b", obs, want); end
        applyStimulus(1,0,0,0,0);
        checks++; want = pack(0,0,0,1,0,0,4'd15); if (obs !== want) begin errors++; $display("[TB] FAIL ov_full_reject: got %b want %b", obs, want); end
        applyStimulus(0,0,1,1,0);
        checks++; want = pack(1,1,0,0,0,1,4'd15); if (obs !== want) begin errors++; $display("[TB] FAIL ov_vend1: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,1,0,0,0,1,4'd10); if (obs !== want) begin errors++; $display("[TB] FAIL ov_remainder: got %b want %b", obs, want); end
    endtask

    task automatic test_dual_coin();
        do_reset();
        applyStimulus(1,1,0,0,0);
        checks++; want = pack(0,0,0,1,0,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL dual_first: got %b want %b", obs, want); end
        applyStimulus(1,1,0,0,0);
        checks++; want = pack(0,0,0,1,0,0,4'd4); if (obs !== want) begin errors++; $display("[TB] FAIL dual_second: got %b want %b", obs, want); end
    endtask

    task automatic test_priority();
        do_reset();
        applyStimulus(0,1,0,0,0);
        applyStimulus(0,1,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd4); if (obs !== want) begin errors++; $display("[TB] FAIL pr_credit4: got %b want %b", obs, want); end
        applyStimulus(1,0,1,0,0);
        checks++; want = pack(1,0,0,1,0,1,4'd4); if (obs !== want) begin errors++; $display("[TB] FAIL pr_sel_over_coin: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL pr_change: got %b want %b", obs, want); end
        applyStimulus(0,1,0,0,0);
        applyStimulus(1,0,1,1,1);
        checks++; want = pack(0,0,0,1,0,1,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL pr_cancel_wins: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL pr_refund_done: got %b want %b", obs, want); end
    endtask

    task automatic test_idle_inputs();
        do_reset();
        applyStimulus(0,0,0,0,1);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL idle_cancel: got %b want %b", obs, want); end
        applyStimulus(0,0,1,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL idle_select: got %b want %b", obs, want); end
    endtask

    task automatic test_coin_during_change();
        do_reset();
        applyStimulus(0,1,0,0,0);
        applyStimulus(0,1,0,0,0);
        applyStimulus(0,0,0,0,1);
        checks++; want = pack(0,0,0,0,0,1,4'd4); if (obs !== want) begin errors++; $display("[TB] FAIL cc_cancel: got %b want %b", obs, want); end
        applyStimulus(1,0,0,0,0);
        checks++; want = pack(0,0,1,1,0,1,4'd3); if (obs !== want) begin errors++; $display("[TB] FAIL cc_coin_a: got %b want %b", obs, want); end
        applyStimulus(0,1,1,0,0);
        checks++; want = pack(0,0,1,1,0,1,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL cc_coin_b: got %b want %b", obs, want); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL cc_async_reset: got %b want %b", obs, want); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL cc_no_pulses: got %b want %b", obs, want); end
    endtask

    task automatic test_ena_pause();
        do_reset();
        applyStimulus(1,0,0,0,0);
        applyStimulus(0,1,0,0,0);
        applyStimulus(0,0,0,0,1);
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,1,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL en_first: got %b want %b", obs, want); end
        ena = 1'b0;
        applyStimulus(0,0,0,0,0);
        applyStimulus(1,0,0,0,0);
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,1,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL en_hold: got %b want %b", obs, want); end
        ena = 1'b1;
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,1,4'd1); if (obs !== want) begin errors++; $display("[TB] FAIL en_resume: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL en_last: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL en_idle: got %b want %b", obs, want); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        applyStimulus(1,0,0,0,0);
        applyStimulus(0,1,0,0,0);
        applyStimulus(0,0,1,0,0);
        checks++; want = pack(1,0,0,0,0,1,4'd3); if (obs !== want) begin errors++; $display("[TB] FAIL bb_exact_vend: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL bb_no_change: got %b want %b", obs, want); end
        applyStimulus(0,1,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL bb_next_coin: got %b want %b", obs, want); end
    endtask

    task automatic test_timeout();
        do_reset();
        applyStimulus(0,1,0,0,0);
        repeat (7) applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL to_before: got %b want %b", obs, want); end
`ifdef VEND_TIMEOUT_EN
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,1,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL to_fire: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,1,4'd1); if (obs !== want) begin errors++; $display("[TB] FAIL to_change1: got %b want %b", obs, want); end
        applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,1,0,0,0,4'd0); if (obs !== want) begin errors++; $display("[TB] FAIL to_change2: got %b want %b", obs, want); end
`else
        repeat (20) applyStimulus(0,0,0,0,0);
        checks++; want = pack(0,0,0,0,0,0,4'd2); if (obs !== want) begin errors++; $display("[TB] FAIL to_held: got %b want %b", obs, want); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vend_with_change();
        test_deny_cancel();
        test_overflow();
        test_dual_coin();
        test_priority();
        test_idle_inputs();
        test_coin_during_change();
        test_ena_pause();
        test_back_to_back();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends even if the sequence above stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
